// File: rtl/coil_pkg.sv
// Shared types and default timing constants for the coil sequencer.
// All timing counters are CNT_W bits wide.
package coil_pkg;

    localparam int unsigned CNT_W = 32;

    localparam int unsigned DEF_NSTAGE     = 3;
    localparam int unsigned DEF_CHARGE_CYC = 100000000;
    localparam int unsigned DEF_FIRE_CYC   = 50000;
    localparam int unsigned DEF_GAP_CYC    = 10000;
    localparam int unsigned DEF_COOL_CYC   = 50000000;
    localparam int unsigned DEF_PWM_PERIOD = 588000;
    localparam int unsigned DEF_DUTY_IDLE  = 20000;
    localparam int unsigned DEF_DUTY_FIRE  = 10000;

    typedef enum logic [2:0] {
        IDLE,
        CHARGE,
        FIRE,
        GAP,
        COOL
    } coil_state_t;

endpackage

// File: rtl/coil_pwm.sv
// Servo PWM generator: free-running period counter plus a duty register
// that only takes a new value at the period boundary.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   duty - requested high-time in cycles (sampled at period wrap)
//   pwm  - registered PWM output, high while counter < latched duty
module coil_pwm
    import coil_pkg::*;
#(
    parameter int unsigned PERIOD   = DEF_PWM_PERIOD,
    parameter int unsigned DUTY_RST = DEF_DUTY_IDLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_q;

    // pwm is computed from the next counter/duty values so it lines up with cnt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            duty_q <= CNT_W'(DUTY_RST);
            pwm    <= (DUTY_RST != 0);
        end else if (cnt == CNT_W'(PERIOD - 1)) begin
            cnt    <= '0;
            duty_q <= duty;
            pwm    <= (duty != '0);
        end else begin
            cnt <= cnt + CNT_W'(1);
            pwm <= ((cnt + CNT_W'(1)) < duty_q);
        end
    end

endmodule

// File: rtl/coil_seq.sv
// Coil-gun shot sequencer: charge, fire NSTAGE coils one at a time with a
// dead gap between them, then a cool-down lockout. A servo PWM switches
// to the firing duty while coils are being driven.
// Ports:
//   clk, rst   - system clock, asynchronous active-high reset
//   trig       - raw pushbutton; a synchronised rising edge starts a shot
//   abort      - raw abort request (acted on only with COIL_ABORT_EN)
//   charge_n   - charger enable, active low
//   stage_en   - one-hot coil drive
//   servo_pwm  - servo PWM output
//   busy       - high whenever the sequencer is not idle
//   done       - one-cycle pulse when a shot completes
// Build option: define COIL_ABORT_EN to make abort return to IDLE at once.
module coil_seq
    import coil_pkg::*;
#(
    parameter int unsigned NSTAGE     = DEF_NSTAGE,
    parameter int unsigned CHARGE_CYC = DEF_CHARGE_CYC,
    parameter int unsigned FIRE_CYC   = DEF_FIRE_CYC,
    parameter int unsigned GAP_CYC    = DEF_GAP_CYC,
    parameter int unsigned COOL_CYC   = DEF_COOL_CYC,
    parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
    parameter int unsigned DUTY_IDLE  = DEF_DUTY_IDLE,
    parameter int unsigned DUTY_FIRE  = DEF_DUTY_FIRE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    output logic              charge_n,
    output logic [NSTAGE-1:0] stage_en,
    output logic              servo_pwm,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    coil_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             trig_s1;
    logic             trig_s2;
    logic             trig_q;
    logic             trig_rise;
    logic [CNT_W-1:0] duty_sel;

    // Two-flop synchroniser plus one history flop for rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_q  <= trig_s2;
        end
    end

    assign trig_rise = trig_s2 & ~trig_q;

`ifdef COIL_ABORT_EN
    logic abort_s1;
    logic abort_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_s1 <= 1'b0;
            abort_s2 <= 1'b0;
        end else begin
            abort_s1 <= abort;
            abort_s2 <= abort_s1;
        end
    end
`else
    logic abort_unused;
    assign abort_unused = abort;
`endif

    // Sequencer FSM; outputs are registered alongside each transition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            charge_n <= 1'b1;
            stage_en <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end
`ifdef COIL_ABORT_EN
        else if (abort_s2) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            charge_n <= 1'b1;
            stage_en <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end
`endif
        else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state    <= CHARGE;
                        cnt      <= CNT_W'(CHARGE_CYC - 1);
                        charge_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CHARGE: begin
                    if (cnt == '0) begin
                        state    <= FIRE;
                        idx      <= '0;
                        cnt      <= CNT_W'(FIRE_CYC - 1);
                        charge_n <= 1'b1;
                        stage_en <= NSTAGE'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIRE: begin
                    if (cnt == '0) begin
                        stage_en <= '0;
                        if (CNT_W'(idx) < CNT_W'(NSTAGE - 1)) begin
                            state <= GAP;
                            cnt   <= CNT_W'(GAP_CYC - 1);
                        end else begin
                            state <= COOL;
                            cnt   <= CNT_W'(COOL_CYC - 1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state    <= FIRE;
                        idx      <= idx + IDX_W'(1);
                        cnt      <= CNT_W'(FIRE_CYC - 1);
                        stage_en <= NSTAGE'(1) << (idx + IDX_W'(1));
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                COOL: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    idx      <= '0;
                    charge_n <= 1'b1;
                    stage_en <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Servo sits at the firing position while coils are being driven
    assign duty_sel = (state == FIRE || state == GAP) ? CNT_W'(DUTY_FIRE)
                                                      : CNT_W'(DUTY_IDLE);

    coil_pwm #(
        .PERIOD   (PWM_PERIOD),
        .DUTY_RST (DUTY_IDLE)
    ) u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (duty_sel),
        .pwm  (servo_pwm)
    );

endmodule

// File: tb/tb_coil_seq.sv
// Self-checking bench for coil_seq with short timing parameters.
// Expected per-cycle outputs are queued when stimulus is applied and
// popped as the DUT advances. Abort expectations follow COIL_ABORT_EN.
module tb_coil_seq;

    localparam int unsigned NSTAGE     = 3;
    localparam int unsigned CHARGE_CYC = 10;
    localparam int unsigned FIRE_CYC   = 4;
    localparam int unsigned GAP_CYC    = 2;
    localparam int unsigned COOL_CYC   = 5;
    localparam int unsigned PWM_PERIOD = 20;
    localparam int unsigned DUTY_IDLE  = 8;
    localparam int unsigned DUTY_FIRE  = 4;

    typedef struct packed {
        logic       charge_n;
        logic [2:0] stage_en;
        logic       busy;
        logic       done;
    } obs_t;

    logic              clk;
    logic              rst;
    logic              trig;
    logic              abort;
    logic              charge_n;
    logic [NSTAGE-1:0] stage_en;
    logic              servo_pwm;
    logic              busy;
    logic              done;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    logic pwm_q[$];

    coil_seq #(
        .NSTAGE     (NSTAGE),
        .CHARGE_CYC (CHARGE_CYC),
        .FIRE_CYC   (FIRE_CYC),
        .GAP_CYC    (GAP_CYC),
        .COOL_CYC   (COOL_CYC),
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_IDLE  (DUTY_IDLE),
        .DUTY_FIRE  (DUTY_FIRE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .abort     (abort),
        .charge_n  (charge_n),
        .stage_en  (stage_en),
        .servo_pwm (servo_pwm),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_seg(input logic cn, input logic [2:0] se, input logic b,
                            input logic d, input int n);
        obs_t v;
        v = {cn, se, b, d};
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Expected cycle-by-cycle outputs from the first CHARGE cycle onward
    task automatic push_shot();
        push_seg(1'b0, 3'b000, 1'b1, 1'b0, 10);
        push_seg(1'b1, 3'b001, 1'b1, 1'b0, 4);
        push_seg(1'b1, 3'b000, 1'b1, 1'b0, 2);
        push_seg(1'b1, 3'b010, 1'b1, 1'b0, 4);
        push_seg(1'b1, 3'b000, 1'b1, 1'b0, 2);
        push_seg(1'b1, 3'b100, 1'b1, 1'b0, 4);
        push_seg(1'b1, 3'b000, 1'b1, 1'b0, 5);
        push_seg(1'b1, 3'b000, 1'b0, 1'b1, 1);
        push_seg(1'b1, 3'b000, 1'b0, 1'b0, 4);
    endtask

    // Fire one shot and compare every cycle; optional re-trigger and abort points
    task automatic run_shot(input string name, input int retrig_at, input int abort_at);
        obs_t cur;
        obs_t want;
        int   i;
        int   w;
        push_shot();
        trig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        trig = 1'b0;
        w = 0;
        while (charge_n !== 1'b0 && w < 12) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (charge_n !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: charge_n=%b after %0d cycles, required 0", name, charge_n, w);
            exp_q.delete();
            return;
        end
        i = 0;
        while (exp_q.size() > 0) begin
            cur  = {charge_n, stage_en, busy, done};
            want = exp_q.pop_front();
            checks++;
            if (cur !== want) begin
                errors++;
                $display("FAIL %s_cycle%0d: got cn/se/busy/done=%b required %b", name, i, cur, want);
            end
            if (retrig_at >= 0 && i == retrig_at) trig = 1'b1;
            if (retrig_at >= 0 && i == retrig_at + 2) trig = 1'b0;
            if (i == abort_at) begin
                abort = 1'b1;
`ifdef COIL_ABORT_EN
                repeat (3) @(posedge clk);
                #1;
                checks++;
                if (stage_en !== 3'b000 || busy !== 1'b0 || charge_n !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_abort_idle: se=%b busy=%b cn=%b required 000/0/1",
                             name, stage_en, busy, charge_n);
                end
                w = 0;
                repeat (15) begin
                    @(negedge clk);
                    if (done === 1'b1) w++;
                end
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL %s_abort_done: done pulses=%0d required 0", name, w);
                end
                abort = 1'b0;
                exp_q.delete();
                repeat (5) @(negedge clk);
                return;
`endif
            end
            i++;
            @(negedge clk);
        end
        abort = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t cur;
        rst   = 1'b1;
        trig  = 1'b0;
        abort = 1'b0;
        #1;
        cur = {charge_n, stage_en, busy, done};
        checks++;
        if (cur !== 6'b1_000_0_0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 100000", cur);
        end
        checks++;
        if (servo_pwm !== 1'b1) begin
            errors++;
            $display("FAIL reset_pwm: got %b required 1", servo_pwm);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        cur = {charge_n, stage_en, busy, done};
        checks++;
        if (cur !== 6'b1_000_0_0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 100000", cur);
        end
    endtask

    task automatic test_pwm();
        logic prev;
        logic want;
        int   w;
        int   i;
        int   highs;
        // find a period start: first high sample after a low one
        prev = servo_pwm;
        @(negedge clk);
        w = 0;
        while (!(prev === 1'b0 && servo_pwm === 1'b1) && w < 45) begin
            prev = servo_pwm;
            @(negedge clk);
            w++;
        end
        checks++;
        if (!(prev === 1'b0 && servo_pwm === 1'b1)) begin
            errors++;
            $display("FAIL pwm_align: no rising edge within %0d cycles", w);
            return;
        end
        for (int k = 0; k < 20; k++) pwm_q.push_back(k < 8);
        highs = 0;
        i = 0;
        while (pwm_q.size() > 0) begin
            want = pwm_q.pop_front();
            checks++;
            if (servo_pwm !== want) begin
                errors++;
                $display("FAIL pwm_idle_%0d: got %b required %b", i, servo_pwm, want);
            end
            if (servo_pwm === 1'b1) highs++;
            i++;
            @(negedge clk);
        end
        checks++;
        if (highs != 8) begin
            errors++;
            $display("FAIL pwm_idle_highs: got %0d required 8", highs);
        end
        // shot launched at a period start; FIRE begins mid-period so the
        // first period keeps the idle duty, the next uses the fire duty
        for (int k = 0; k < 20; k++) pwm_q.push_back(k < 8);
        for (int k = 0; k < 20; k++) pwm_q.push_back(k < 4);
        for (int k = 0; k < 20; k++) pwm_q.push_back(k < 8);
        trig = 1'b1;
        i = 0;
        while (pwm_q.size() > 0) begin
            want = pwm_q.pop_front();
            checks++;
            if (servo_pwm !== want) begin
                errors++;
                $display("FAIL pwm_shot_%0d: got %b required %b", i, servo_pwm, want);
            end
            if (i == 2) trig = 1'b0;
            i++;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_full_shot();
        run_shot("full", -1, -1);
    endtask

    task automatic test_retrigger();
        run_shot("retrig", 3, -1);
    endtask

    task automatic test_abort();
        run_shot("abort", -1, 16);
`ifdef COIL_ABORT_EN
        run_shot("after_abort", -1, -1);
`endif
    endtask

    task automatic test_reset_mid_shot();
        obs_t cur;
        int   w;
        // reset while a coil is energised
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        w = 0;
        while (stage_en !== 3'b010 && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (stage_en !== 3'b010) begin
            errors++;
            $display("FAIL rst_fire_reach: se=%b required 010", stage_en);
        end
        #2 rst = 1'b1;
        #1;
        cur = {charge_n, stage_en, busy, done};
        checks++;
        if (cur !== 6'b1_000_0_0) begin
            errors++;
            $display("FAIL rst_fire_async: got %b required 100000", cur);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        // reset during GAP
        trig = 1'b1;
        repeat (2) @(negedge clk);
        trig = 1'b0;
        w = 0;
        while (stage_en !== 3'b010 && w < 40) begin
            @(negedge clk);
            w++;
        end
        while (stage_en !== 3'b000 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (stage_en !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_gap_reach: se=%b busy=%b required 000/1", stage_en, busy);
        end
        #2 rst = 1'b1;
        #1;
        cur = {charge_n, stage_en, busy, done};
        checks++;
        if (cur !== 6'b1_000_0_0 || servo_pwm !== 1'b1) begin
            errors++;
            $display("FAIL rst_gap_async: got %b pwm=%b required 100000 pwm=1", cur, servo_pwm);
        end
        @(negedge clk);
        rst = 1'b0;
        w = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0 || charge_n !== 1'b1 || stage_en !== 3'b000) w++;
        end
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL rst_gap_no_resume: active cycles=%0d required 0", w);
        end
        run_shot("after_reset", -1, -1);
    endtask

    initial begin
        test_reset();
        test_pwm();
        test_full_shot();
        test_retrigger();
        test_abort();
        test_reset_mid_shot();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coil_seq.md
COIL_SEQ -- requirements
Module: coil_seq

Interface
- REQ-001 SHALL have parameter NSTAGE, default 3, meaning the number of coil stages fired in order.
- REQ-002 SHALL have parameter CHARGE_CYC, default 100000000, meaning the charge time in clk cycles.
- REQ-003 SHALL have parameter FIRE_CYC, default 50000, meaning the on-time of each stage in cycles.
- REQ-004 SHALL have parameter GAP_CYC, default 10000, meaning the dead time between stages in cycles.
- REQ-005 SHALL have parameter COOL_CYC, default 50000000, meaning the post-shot lockout in cycles.
- REQ-006 SHALL have parameter PWM_PERIOD, default 588000, meaning the servo PWM period in cycles.
- REQ-007 SHALL have parameters DUTY_IDLE (default 20000) and DUTY_FIRE (default 10000), meaning the servo high-time in cycles when idle and when firing.
- REQ-008 SHALL have port clk, input, 1 bit, the system clock.
- REQ-009 SHALL have port rst, input, 1 bit, reset: asynchronous, active-high.
- REQ-010 SHALL have port trig, input, 1 bit, a raw asynchronous pushbutton.
- REQ-011 SHALL have port abort, input, 1 bit, a raw asynchronous abort request.
- REQ-012 SHALL have port charge_n, output, 1 bit, the charger enable (active low).
- REQ-013 SHALL have port stage_en, output, NSTAGE bits, the one-hot coil drive.
- REQ-014 SHALL have port servo_pwm, output, 1 bit, the servo PWM.
- REQ-015 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
- REQ-016 SHALL have port done, output, 1 bit, a one-cycle pulse when a shot completes.

Function
- REQ-017 SHALL synchronise trig and abort through 2 flops each and act on a trig rising edge only; trig and abort reach the FSM 2 clk cycles after they change.
- REQ-018 SHALL implement the states IDLE, CHARGE, FIRE, GAP and COOL with a single shared down-counter.
- REQ-019 SHALL move IDLE->CHARGE on a trig edge, loading the counter with CHARGE_CYC-1; charge_n is 0 in CHARGE.
- REQ-020 SHALL move CHARGE->FIRE when the counter reaches 0, with stage index 0 and the counter loaded with FIRE_CYC-1.
- REQ-021 SHALL drive stage_en[idx]=1 in FIRE and keep all other stage_en bits at 0.
- REQ-022 SHALL, when the FIRE counter reaches 0, go to GAP (counter=GAP_CYC-1) if idx<NSTAGE-1, else go to COOL (counter=COOL_CYC-1).
- REQ-023 SHALL move GAP->FIRE with idx+1 when the counter reaches 0.
- REQ-024 SHALL keep stage_en all 0 in GAP, so no two stages are ever on in the same or adjacent cycles.
- REQ-025 SHALL move COOL->IDLE when the counter reaches 0, pulsing done for exactly 1 cycle on that transition.
- REQ-026 SHALL ignore trig edges in any state other than IDLE; these edges are not queued.
- REQ-027 SHALL treat a counter value of 0 at load (parameter value 1) as a dwell of 1 cycle in that state.
- REQ-028 SHALL select the servo duty as DUTY_FIRE in FIRE and GAP and DUTY_IDLE otherwise.
- REQ-029 SHALL latch the selected duty only at a PWM period boundary, so no period is glitched.
- REQ-030 SHALL make servo_pwm high while the PWM counter is less than the latched duty.
- REQ-031 SHALL use 32-bit counters for all timing; the PWM counter wraps from PWM_PERIOD-1 to 0.

Reset
- REQ-032 SHALL, on rst, immediately set state=IDLE, charge_n=1, stage_en=0, busy=0, done=0, idx=0 and the counter to 0.
- REQ-033 SHALL, on rst, set the PWM counter to 0, the latched duty to DUTY_IDLE, and the synchroniser flops to 0.
- REQ-034 SHALL, when rst is asserted mid-shot, de-energise all coils asynchronously without waiting for a clk edge.

Configuration
- REQ-035 SHALL, with COIL_ABORT_EN defined, respond to a synchronised abort=1 in any state by going to IDLE on the next clk edge.
- REQ-036 SHALL, on that abort, set charge_n=1 and stage_en=0 and SHALL NOT pulse done.
- REQ-037 SHALL, with COIL_ABORT_EN undefined, keep the abort port but ignore it entirely.

Structure
- REQ-038 SHALL place the state enum coil_state_t and the default timing constants in package coil_pkg.
- REQ-039 SHALL implement the servo PWM as sub-module coil_pwm, with inputs clk, rst and duty and output pwm; coil_pwm owns the period counter and the boundary latch.

Verification (NSTAGE=3, CHARGE_CYC=10, FIRE_CYC=4, GAP_CYC=2, COOL_CYC=5, PWM_PERIOD=20, DUTY_IDLE=8, DUTY_FIRE=4)
- REQ-040 SHALL cover a full shot: trig pulse -> charge_n low for 10 cycles, then stage_en 001/000/010/000/100 for 4/2/4/2/4 cycles, then 5 COOL cycles, then done high for 1 cycle.
- REQ-041 SHALL cover a re-trigger during CHARGE: a second trig edge -> no change to the timeline, and only one done.
- REQ-042 SHALL cover abort with COIL_ABORT_EN defined: abort asserted during stage 1 FIRE -> stage_en=0 and state IDLE within 3 cycles, no done, and the next trig starts a clean shot.
- REQ-043 SHALL cover abort with COIL_ABORT_EN undefined: the same stimulus -> full shot completes and done pulses.
- REQ-044 SHALL cover PWM: idle -> 8 high / 12 low cycles per period; a shot starting mid-period -> duty changes to 4 only at the next period boundary.
- REQ-045 SHALL cover reset during GAP: rst asserted -> all outputs at reset values with no clk edge, and the shot resumes only on a new trig edge.
